// File: rtl/vp_ctrl_pkg.sv
// Shared types and defaults for the vector-processor pipeline controller.
// Holds the controller state encoding, register index type and timeout default.
package vp_ctrl_pkg;
  localparam int VP_NREG         = 16;
  localparam int MEM_TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} ctrl_state_t;
  typedef logic [$clog2(VP_NREG)-1:0] reg_idx_t;
endpackage

// File: rtl/vp_scoreboard.sv
// Write-pending bits for the scalar and vector register files.
// Lookups are combinational and see a same-cycle WB clear; a same-cycle set beats the clear.
module vp_scoreboard #(
  parameter int NREG = 16,
  parameter int IW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [IW-1:0] set_idx,
  input  logic          set_vec,
  input  logic          clr_en,
  input  logic [IW-1:0] clr_idx,
  input  logic          clr_vec,
  input  logic [IW-1:0] lk1_idx,
  input  logic          lk1_vec,
  input  logic [IW-1:0] lk2_idx,
  input  logic          lk2_vec,
  input  logic [IW-1:0] lk3_idx,
  input  logic          lk3_vec,
  output logic          lk1_pend,
  output logic          lk2_pend,
  output logic          lk3_pend
);
  logic [NREG-1:0] pend_s_q, pend_s_d, pend_v_q, pend_v_d;
  logic [NREG-1:0] clr_s, clr_v, set_s, set_v, eff_s, eff_v;

  always_comb begin
    clr_s = '0;
    clr_v = '0;
    set_s = '0;
    set_v = '0;
    if (clr_en) begin
      if (clr_vec) clr_v[clr_idx] = 1'b1;
      else         clr_s[clr_idx] = 1'b1;
    end
    if (set_en) begin
      if (set_vec) set_v[set_idx] = 1'b1;
      else         set_s[set_idx] = 1'b1;
    end
    // Register file writes before it reads, so a retiring write never blocks
    eff_s    = pend_s_q & ~clr_s;
    eff_v    = pend_v_q & ~clr_v;
    pend_s_d = eff_s | set_s;
    pend_v_d = eff_v | set_v;
    lk1_pend = lk1_vec ? eff_v[lk1_idx] : eff_s[lk1_idx];
    lk2_pend = lk2_vec ? eff_v[lk2_idx] : eff_s[lk2_idx];
    lk3_pend = lk3_vec ? eff_v[lk3_idx] : eff_s[lk3_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_s_q <= '0;
      pend_v_q <= '0;
    end else begin
      pend_s_q <= pend_s_d;
      pend_v_q <= pend_v_d;
    end
  end
endmodule

// File: rtl/vp_pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage vector pipe: RAW/WAW stalls, MEM-stage freeze, timeout fault.
// Stall/issue outputs are combinational; mem_req and fault are registered.
module vp_pipe_hazard_ctrl
  import vp_ctrl_pkg::*;
#(
  parameter int NREG        = VP_NREG,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [$clog2(NREG)-1:0] id_src1,
  input  logic                    id_src1_vec,
  input  logic                    id_src1_use,
  input  logic [$clog2(NREG)-1:0] id_src2,
  input  logic                    id_src2_vec,
  input  logic                    id_src2_use,
  input  logic [$clog2(NREG)-1:0] id_dest,
  input  logic                    id_dest_vec,
  input  logic                    id_wr_en,
  input  logic                    id_is_mem,
  input  logic                    wb_valid,
  input  logic [$clog2(NREG)-1:0] wb_dest,
  input  logic                    wb_dest_vec,
  input  logic                    mem_done,
  output logic                    issue,
  output logic                    stall_if,
  output logic                    bubble_ex,
  output logic                    freeze,
  output logic                    mem_req,
  output logic                    fault
);
  localparam int IW = $clog2(NREG);
  localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(MEM_TIMEOUT - 1);

  ctrl_state_t   state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          fault_q, fault_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          ex_mem_q, ex_mem_d;
  logic          mem_mem_q, mem_mem_d;
  logic          src1_pend, src2_pend, dest_pend;
  logic          hazard, sb_set_en, sb_clr_en;

  assign sb_set_en = issue & id_wr_en;
  // A faulted pipe keeps its scoreboard exactly as it was for post-mortem
  assign sb_clr_en = wb_valid & (state_q != FAULT);

  vp_scoreboard #(.NREG(NREG), .IW(IW)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (sb_set_en),
    .set_idx  (id_dest),
    .set_vec  (id_dest_vec),
    .clr_en   (sb_clr_en),
    .clr_idx  (wb_dest),
    .clr_vec  (wb_dest_vec),
    .lk1_idx  (id_src1),
    .lk1_vec  (id_src1_vec),
    .lk2_idx  (id_src2),
    .lk2_vec  (id_src2_vec),
    .lk3_idx  (id_dest),
    .lk3_vec  (id_dest_vec),
    .lk1_pend (src1_pend),
    .lk2_pend (src2_pend),
    .lk3_pend (dest_pend)
  );

  always_comb begin
    case (state_q)
      MEM_WAIT: freeze = ~mem_done;
      FAULT:    freeze = 1'b1;
      default:  freeze = 1'b0;
    endcase
    hazard    = id_valid & ((id_src1_use & src1_pend) | (id_src2_use & src2_pend)
                            | (id_wr_en & dest_pend));
    issue     = id_valid & ~hazard & ~freeze;
    stall_if  = hazard | freeze;
    bubble_ex = hazard & ~freeze;
  end

  always_comb begin
    state_d   = state_q;
    mem_req_d = 1'b0;
    fault_d   = fault_q;
    tcnt_d    = tcnt_q;
    ex_mem_d  = ex_mem_q;
    mem_mem_d = mem_mem_q;
    if (!freeze) begin
      ex_mem_d  = issue & id_is_mem;
      mem_mem_d = ex_mem_q;
    end
    case (state_q)
      RUN: begin
        if (ex_mem_q) begin
          state_d   = MEM_WAIT;
          mem_req_d = 1'b1;
          tcnt_d    = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_done) begin
          // A mem op waiting in EX follows straight into MEM with no idle cycle
          if (ex_mem_q) begin
            mem_req_d = 1'b1;
            tcnt_d    = '0;
          end else begin
            state_d = RUN;
          end
        end else if (tcnt_q == TLAST) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: fault_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      mem_req_q <= 1'b0;
      fault_q   <= 1'b0;
      tcnt_q    <= '0;
      ex_mem_q  <= 1'b0;
      mem_mem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
      fault_q   <= fault_d;
      tcnt_q    <= tcnt_d;
      ex_mem_q  <= ex_mem_d;
      mem_mem_q <= mem_mem_d;
    end
  end

  assign mem_req = mem_req_q;
  assign fault   = fault_q;
endmodule

// File: tb/tb_vp_pipe_hazard_ctrl.sv
// Directed and randomized checks of vp_pipe_hazard_ctrl against a behavioural pipe model.
module tb_vp_pipe_hazard_ctrl;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_src1_vec, id_src1_use, id_src2_vec, id_src2_use;
  logic [3:0] id_src1, id_src2, id_dest, wb_dest;
  logic       id_dest_vec, id_wr_en, id_is_mem, wb_valid, wb_dest_vec, mem_done;
  logic       issue, stall_if, bubble_ex, freeze, mem_req, fault;

  int total = 0;
  int bad   = 0;

  // Model: pending registers per file, controller mode (0 run, 1 waiting on memory, 2 faulted)
  bit ps[16];
  bit pv[16];
  int m_mode;
  int m_wait;
  bit m_ex;
  bit m_mreq;
  bit e_issue, e_stall, e_bub, e_frz;

  always #5 clk = ~clk;

  vp_pipe_hazard_ctrl #(.NREG(16), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_src1(id_src1), .id_src1_vec(id_src1_vec), .id_src1_use(id_src1_use),
    .id_src2(id_src2), .id_src2_vec(id_src2_vec), .id_src2_use(id_src2_use),
    .id_dest(id_dest), .id_dest_vec(id_dest_vec), .id_wr_en(id_wr_en), .id_is_mem(id_is_mem),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_dest_vec(wb_dest_vec), .mem_done(mem_done),
    .issue(issue), .stall_if(stall_if), .bubble_ex(bubble_ex), .freeze(freeze),
    .mem_req(mem_req), .fault(fault)
  );

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  function automatic bit busy(input logic [3:0] idx, input logic vec);
    bit retiring;
    retiring = wb_valid && (m_mode != 2) && (wb_dest == idx) && (wb_dest_vec == vec);
    return (vec ? pv[idx] : ps[idx]) && !retiring;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      ps[i] = 1'b0;
      pv[i] = 1'b0;
    end
    m_mode = 0;
    m_wait = 0;
    m_ex   = 1'b0;
    m_mreq = 1'b0;
  endtask

  task automatic model_comb();
    bit hz;
    hz = id_valid && ((id_src1_use && busy(id_src1, id_src1_vec)) ||
                      (id_src2_use && busy(id_src2, id_src2_vec)) ||
                      (id_wr_en && busy(id_dest, id_dest_vec)));
    e_frz   = (m_mode == 2) || (m_mode == 1 && !mem_done);
    e_issue = id_valid && !hz && !e_frz;
    e_stall = hz || e_frz;
    e_bub   = hz && !e_frz;
  endtask

  task automatic model_seq();
    bit nxt_req;
    nxt_req = 1'b0;
    if (wb_valid && m_mode != 2) begin
      if (wb_dest_vec) pv[wb_dest] = 1'b0;
      else             ps[wb_dest] = 1'b0;
    end
    if (e_issue && id_wr_en) begin
      if (id_dest_vec) pv[id_dest] = 1'b1;
      else             ps[id_dest] = 1'b1;
    end
    if (m_mode == 0) begin
      if (m_ex) begin
        m_mode  = 1;
        m_wait  = 0;
        nxt_req = 1'b1;
      end
    end else if (m_mode == 1) begin
      if (mem_done) begin
        if (m_ex) begin
          m_wait  = 0;
          nxt_req = 1'b1;
        end else begin
          m_mode = 0;
        end
      end else begin
        m_wait++;
        if (m_wait == TO) m_mode = 2;
      end
    end
    if (!e_frz) m_ex = e_issue && id_is_mem;
    m_mreq = nxt_req;
  endtask

  task automatic eval();
    model_comb();
    @(negedge clk);
    chk("issue", issue, e_issue);
    chk("stall_if", stall_if, e_stall);
    chk("bubble_ex", bubble_ex, e_bub);
    chk("freeze", freeze, e_frz);
    chk("mem_req", mem_req, m_mreq);
    chk("fault", fault, m_mode == 2);
  endtask

  task automatic adv();
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic step();
    eval();
    adv();
  endtask

  task automatic idle();
    id_valid = 0; id_src1 = 0; id_src1_vec = 0; id_src1_use = 0;
    id_src2 = 0; id_src2_vec = 0; id_src2_use = 0;
    id_dest = 0; id_dest_vec = 0; id_wr_en = 0; id_is_mem = 0;
    wb_valid = 0; wb_dest = 0; wb_dest_vec = 0; mem_done = 0;
  endtask

  task automatic set_id(input logic v, input logic [3:0] s1, input logic s1v, input logic s1u,
                        input logic [3:0] s2, input logic s2v, input logic s2u,
                        input logic [3:0] d, input logic dv, input logic we, input logic mem);
    id_valid = v; id_src1 = s1; id_src1_vec = s1v; id_src1_use = s1u;
    id_src2 = s2; id_src2_vec = s2v; id_src2_use = s2u;
    id_dest = d; id_dest_vec = dv; id_wr_en = we; id_is_mem = mem;
  endtask

  task automatic set_wb(input logic v, input logic [3:0] d, input logic dv);
    wb_valid = v; wb_dest = d; wb_dest_vec = dv;
  endtask

  task automatic async_reset();
    idle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_fault", fault, 1'b0);
    chk("rst_freeze", freeze, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("reset_issue", issue, 1'b0);
    chk("reset_stall_if", stall_if, 1'b0);
    chk("reset_bubble_ex", bubble_ex, 1'b0);
    chk("reset_freeze", freeze, 1'b0);
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_fault", fault, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // RAW on v3 held until WB of v3, which issues in the same cycle
    set_id(1, 0, 0, 0, 0, 0, 0, 3, 1, 1, 0); step();
    set_id(1, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    eval(); chk("t1_stall", stall_if, 1'b1); chk("t1_bubble", bubble_ex, 1'b1); adv();
    step();
    set_wb(1, 3, 1);
    eval(); chk("t1_wb_issue", issue, 1'b1); chk("t1_wb_stall", stall_if, 1'b0); adv();
    idle();

    // File isolation: pending v5 does not block scalar s5
    set_id(1, 0, 0, 0, 0, 0, 0, 5, 1, 1, 0); step();
    set_id(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    eval(); chk("t2_issue", issue, 1'b1); adv();
    idle(); set_wb(1, 5, 1); step(); idle();

    // WAW on s2, then same-cycle clear and set leaves s2 pending
    set_id(1, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0); step();
    eval(); chk("t3_waw_stall", stall_if, 1'b1); adv();
    set_wb(1, 2, 0);
    eval(); chk("t3_issue", issue, 1'b1); adv();
    set_wb(0, 0, 0);
    set_id(1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    eval(); chk("t3_still_pend", stall_if, 1'b1); adv();
    idle(); set_wb(1, 2, 0); step(); idle();

    // Mem op, mem_done three cycles after mem_req
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    idle(); step();
    eval(); chk("t4_req", mem_req, 1'b1); chk("t4_frz0", freeze, 1'b1); adv();
    eval(); chk("t4_req_low", mem_req, 1'b0); chk("t4_frz1", freeze, 1'b1); adv();
    eval(); chk("t4_frz2", freeze, 1'b1); adv();
    mem_done = 1;
    eval(); chk("t4_done_frz", freeze, 1'b0); adv();
    mem_done = 0;
    eval(); chk("t4_run_frz", freeze, 1'b0); chk("t4_run_req", mem_req, 1'b0); adv();

    // Timeout into FAULT, cleared only by reset
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    idle(); step();
    for (int i = 0; i < TO; i++) step();
    eval(); chk("t5_fault", fault, 1'b1); chk("t5_freeze", freeze, 1'b1); chk("t5_stall", stall_if, 1'b1); adv();
    set_wb(1, 0, 0); mem_done = 1;
    eval(); chk("t5_sticky", fault, 1'b1); adv();
    async_reset();

    // Reset mid-MEM_WAIT with v4..v7 pending
    for (int i = 4; i < 8; i++) begin
      set_id(1, 0, 0, 0, 0, 0, 0, 4'(i), 1, 1, 0); step();
    end
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    idle(); step();
    eval(); chk("t6_waiting", freeze, 1'b1); adv();
    async_reset();
    set_id(1, 4, 1, 1, 5, 1, 1, 0, 0, 0, 0);
    eval(); chk("t6_v45_clear", issue, 1'b1); adv();
    set_id(1, 6, 1, 1, 7, 1, 1, 0, 0, 0, 0);
    eval(); chk("t6_v67_clear", issue, 1'b1); chk("t6_req", mem_req, 1'b0); adv();
    idle();

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      id_valid    = ($urandom_range(0, 9) < 7);
      id_src1     = 4'($urandom_range(0, 3));
      id_src1_vec = 1'($urandom_range(0, 1));
      id_src1_use = 1'($urandom_range(0, 1));
      id_src2     = 4'($urandom_range(0, 3));
      id_src2_vec = 1'($urandom_range(0, 1));
      id_src2_use = 1'($urandom_range(0, 1));
      id_dest     = 4'($urandom_range(0, 3));
      id_dest_vec = 1'($urandom_range(0, 1));
      id_wr_en    = 1'($urandom_range(0, 1));
      id_is_mem   = ($urandom_range(0, 4) == 0);
      wb_valid    = ($urandom_range(0, 9) < 4);
      wb_dest     = 4'($urandom_range(0, 3));
      wb_dest_vec = 1'($urandom_range(0, 1));
      mem_done    = ($urandom_range(0, 9) < 6);
      step();
      if (m_mode == 2 && $urandom_range(0, 2) == 0) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
